// File: rtl/ysyx_210247_pipe_buf_pkg.sv
// Shared constants for the elastic inter-stage buffer: stage bus widths
// (mirroring defines.v), the depth ceiling, and small helpers.
package ysyx_210247_pipe_buf_pkg;

  // Stage bus widths, kept in step with defines.v.
  localparam int IF_TO_ID_BUS   = 64;
  localparam int ID_TO_EXE_BUS  = 64;
  localparam int EXE_TO_MEM_BUS = 64;
  localparam int MEM_TO_WB_BUS  = 64;

  // Largest supported buffer depth.
  localparam int PIPE_BUF_MAX_DEPTH = 8;

  // Per-cycle buffer operation, encoded as {push, pop}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } buf_op_e;

  // Pointer width; a one-entry buffer still carries a 1-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ysyx_210247_pipe_buf_mem.sv
// DEPTH x DW storage array for the pipeline buffer: one write port,
// bulk clear, and a combinational read port.
module ysyx_210247_pipe_buf_mem #(
  parameter int DW    = 64,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  // Next storage contents: clear beats write.
  always_comb begin
    // NOTE: start from the held value so every path assigns mem_d; no latch.
    mem_d = mem_q;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
    end else if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is reset because head data must read 0 out of reset,
      // which rules out mapping it onto an unreset RAM macro.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ysyx_210247_pipe_buf.sv
// Elastic DEPTH-entry pipeline stage with valid/allow handshakes on both
// sides, optional pass-through allow, synchronous flush and occupancy count.
module ysyx_210247_pipe_buf
  import ysyx_210247_pipe_buf_pkg::*;
#(
  parameter int DW             = ID_TO_EXE_BUS,
  parameter int DEPTH          = 2,
  parameter int PASS_ALLOW     = 0,
  parameter int CLEAR_ON_FLUSH = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         up_valid_out,
  input  logic [DW-1:0]                up_data,
  output logic                         up_allow_out,
  output logic                         dn_valid_in,
  output logic [DW-1:0]                dn_data,
  input  logic                         dn_allow_in,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic          CLEAR_EN = (CLEAR_ON_FLUSH != 0);

  if (DEPTH < 1 || DEPTH > PIPE_BUF_MAX_DEPTH) begin : g_depth_check
    $error("ysyx_210247_pipe_buf: DEPTH out of range");
  end

  // Modulo-DEPTH increment; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          push, pop;
  buf_op_e       op;

  // Handshake decode from registered occupancy (plus dn_allow_in when passing).
  always_comb begin
    dn_valid_in = (count_q != '0);
    if (PASS_ALLOW != 0) up_allow_out = (count_q < FULL_CNT) | dn_allow_in;
    else                 up_allow_out = (count_q < FULL_CNT);
    push = up_valid_out & up_allow_out;
    pop  = dn_valid_in & dn_allow_in;
    op   = buf_op_e'({push, pop});
  end

  // Pointer and occupancy update; flush overrides any push or pop.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      case (op)
        OP_PUSH: begin
          count_d  = count_q + 1'b1;
          wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        OP_POP: begin
          count_d  = count_q - 1'b1;
          rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        OP_BOTH: begin
          wr_ptr_d = ptr_inc(wr_ptr_q);
          rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        default: ;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // When full with a same-cycle pop, the write lands on the head slot;
  // the head is read combinationally before the edge, so ordering holds.
  ysyx_210247_pipe_buf_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush & CLEAR_EN),
    .we    (push & ~flush),
    .waddr (wr_ptr_q),
    .wdata (up_data),
    .raddr (rd_ptr_q),
    .rdata (dn_data)
  );

  assign count = count_q;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= FULL_CNT);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count_q == FULL_CNT));

endmodule

// File: tb/tb_ysyx_210247_pipe_buf.sv
// Directed bench for ysyx_210247_pipe_buf. Four instances cover the
// parameter corners: 0 = DEPTH2/PASS0, 1 = DEPTH2/PASS1/CLEAR1,
// 2 = DEPTH3/PASS0, 3 = DEPTH1/PASS1.
module tb_ysyx_210247_pipe_buf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        flush    [4];
  logic        up_valid [4];
  logic [63:0] up_data  [4];
  logic        up_allow [4];
  logic        dn_valid [4];
  logic [63:0] dn_data  [4];
  logic        dn_allow [4];
  logic [1:0]  cnt0, cnt1, cnt2;
  logic [0:0]  cnt3;

  int checks = 0;
  int errors = 0;

  ysyx_210247_pipe_buf #(.DW(64), .DEPTH(2), .PASS_ALLOW(0), .CLEAR_ON_FLUSH(0)) u_d2p0 (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]), .up_valid_out(up_valid[0]),
    .up_data(up_data[0]), .up_allow_out(up_allow[0]), .dn_valid_in(dn_valid[0]),
    .dn_data(dn_data[0]), .dn_allow_in(dn_allow[0]), .count(cnt0));

  ysyx_210247_pipe_buf #(.DW(64), .DEPTH(2), .PASS_ALLOW(1), .CLEAR_ON_FLUSH(1)) u_d2p1 (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]), .up_valid_out(up_valid[1]),
    .up_data(up_data[1]), .up_allow_out(up_allow[1]), .dn_valid_in(dn_valid[1]),
    .dn_data(dn_data[1]), .dn_allow_in(dn_allow[1]), .count(cnt1));

  ysyx_210247_pipe_buf #(.DW(64), .DEPTH(3), .PASS_ALLOW(0), .CLEAR_ON_FLUSH(0)) u_d3p0 (
    .clk(clk), .rst_n(rst_n), .flush(flush[2]), .up_valid_out(up_valid[2]),
    .up_data(up_data[2]), .up_allow_out(up_allow[2]), .dn_valid_in(dn_valid[2]),
    .dn_data(dn_data[2]), .dn_allow_in(dn_allow[2]), .count(cnt2));

  ysyx_210247_pipe_buf #(.DW(64), .DEPTH(1), .PASS_ALLOW(1), .CLEAR_ON_FLUSH(0)) u_d1p1 (
    .clk(clk), .rst_n(rst_n), .flush(flush[3]), .up_valid_out(up_valid[3]),
    .up_data(up_data[3]), .up_allow_out(up_allow[3]), .dn_valid_in(dn_valid[3]),
    .dn_data(dn_data[3]), .dn_allow_in(dn_allow[3]), .count(cnt3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++) begin
      flush[i]    = 1'b0;
      up_valid[i] = 1'b0;
      up_data[i]  = '0;
      dn_allow[i] = 1'b0;
    end
  endtask

  task automatic apply_reset();
    idle_all();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (dn_valid[i] !== 1'b0) begin errors++; $display("FAIL reset_dn_valid[%0d]: got %b want 0", i, dn_valid[i]); end
      checks++; if (dn_data[i] !== 64'd0) begin errors++; $display("FAIL reset_dn_data[%0d]: got %h want 0", i, dn_data[i]); end
      checks++; if (up_allow[i] !== 1'b1) begin errors++; $display("FAIL reset_up_allow[%0d]: got %b want 1", i, up_allow[i]); end
    end
    checks++; if (cnt0 !== 2'd0) begin errors++; $display("FAIL reset_count0: got %0d want 0", cnt0); end
    checks++; if (cnt1 !== 2'd0) begin errors++; $display("FAIL reset_count1: got %0d want 0", cnt1); end
    checks++; if (cnt2 !== 2'd0) begin errors++; $display("FAIL reset_count2: got %0d want 0", cnt2); end
    checks++; if (cnt3 !== 1'd0) begin errors++; $display("FAIL reset_count3: got %0d want 0", cnt3); end
  endtask

  // Scenarios 1 and 2: fill DEPTH=2, then offer 0xC while draining,
  // with and without pass-through allow.
  task automatic test_fill_and_pass();
    apply_reset();
    for (int i = 0; i < 2; i++) begin up_valid[i] = 1'b1; up_data[i] = 64'hA; end
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (dn_valid[i] !== 1'b1) begin errors++; $display("FAIL fill1_dn_valid[%0d]: got %b want 1", i, dn_valid[i]); end
      checks++; if (dn_data[i] !== 64'hA) begin errors++; $display("FAIL fill1_dn_data[%0d]: got %h want a", i, dn_data[i]); end
    end
    checks++; if (cnt0 !== 2'd1) begin errors++; $display("FAIL fill1_count0: got %0d want 1", cnt0); end
    checks++; if (cnt1 !== 2'd1) begin errors++; $display("FAIL fill1_count1: got %0d want 1", cnt1); end
    for (int i = 0; i < 2; i++) up_data[i] = 64'hB;
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (up_allow[i] !== 1'b0) begin errors++; $display("FAIL fill2_up_allow[%0d]: got %b want 0", i, up_allow[i]); end
      checks++; if (dn_data[i] !== 64'hA) begin errors++; $display("FAIL fill2_dn_data[%0d]: got %h want a", i, dn_data[i]); end
    end
    checks++; if (cnt0 !== 2'd2) begin errors++; $display("FAIL fill2_count0: got %0d want 2", cnt0); end
    checks++; if (cnt1 !== 2'd2) begin errors++; $display("FAIL fill2_count1: got %0d want 2", cnt1); end

    for (int i = 0; i < 2; i++) begin up_data[i] = 64'hC; dn_allow[i] = 1'b1; end
    #1;
    checks++; if (up_allow[0] !== 1'b0) begin errors++; $display("FAIL full_allow_pass0: got %b want 0", up_allow[0]); end
    checks++; if (up_allow[1] !== 1'b1) begin errors++; $display("FAIL full_allow_pass1: got %b want 1", up_allow[1]); end
    tick();
    checks++; if (cnt0 !== 2'd1) begin errors++; $display("FAIL pass0_pop_count: got %0d want 1", cnt0); end
    checks++; if (dn_data[0] !== 64'hB) begin errors++; $display("FAIL pass0_pop_head: got %h want b", dn_data[0]); end
    checks++; if (cnt1 !== 2'd2) begin errors++; $display("FAIL pass1_both_count: got %0d want 2", cnt1); end
    checks++; if (dn_data[1] !== 64'hB) begin errors++; $display("FAIL pass1_both_head: got %h want b", dn_data[1]); end
    up_valid[1] = 1'b0;
    #1;
    checks++; if (up_allow[0] !== 1'b1) begin errors++; $display("FAIL pass0_retry_allow: got %b want 1", up_allow[0]); end
    tick();
    checks++; if (cnt0 !== 2'd1) begin errors++; $display("FAIL pass0_retry_count: got %0d want 1", cnt0); end
    checks++; if (dn_data[0] !== 64'hC) begin errors++; $display("FAIL pass0_retry_head: got %h want c", dn_data[0]); end
    checks++; if (cnt1 !== 2'd1) begin errors++; $display("FAIL pass1_drain_count: got %0d want 1", cnt1); end
    checks++; if (dn_data[1] !== 64'hC) begin errors++; $display("FAIL pass1_drain_head: got %h want c", dn_data[1]); end
    up_valid[0] = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (dn_valid[i] !== 1'b0) begin errors++; $display("FAIL drained_dn_valid[%0d]: got %b want 0", i, dn_valid[i]); end
    end
    checks++; if (cnt0 !== 2'd0) begin errors++; $display("FAIL drained_count0: got %0d want 0", cnt0); end
    checks++; if (cnt1 !== 2'd0) begin errors++; $display("FAIL drained_count1: got %0d want 0", cnt1); end
    idle_all();
  endtask

  // Scenario 3: DEPTH=3 stream of 1..7, downstream allow toggling.
  task automatic test_wrap();
    int          next_in;
    int          next_out;
    int          mcnt;
    bit          mallow, mpush, mpop;
    logic [63:0] q[$];
    apply_reset();
    next_in = 1; next_out = 1; mcnt = 0;
    for (int cyc = 0; cyc < 40 && next_out <= 7; cyc++) begin
      dn_allow[2] = (cyc % 2 == 1);
      up_valid[2] = (next_in <= 7);
      up_data[2]  = 64'(next_in);
      #1;
      mallow = (mcnt < 3);
      checks++; if (up_allow[2] !== mallow) begin errors++; $display("FAIL wrap_up_allow c%0d: got %b want %b", cyc, up_allow[2], mallow); end
      checks++; if (dn_valid[2] !== (mcnt != 0)) begin errors++; $display("FAIL wrap_dn_valid c%0d: got %b want %b", cyc, dn_valid[2], mcnt != 0); end
      checks++; if (cnt2 !== 2'(mcnt)) begin errors++; $display("FAIL wrap_count c%0d: got %0d want %0d", cyc, cnt2, mcnt); end
      mpop  = (mcnt != 0) && dn_allow[2];
      mpush = up_valid[2] && mallow;
      if (mpop) begin
        checks++; if (dn_data[2] !== 64'(next_out)) begin errors++; $display("FAIL wrap_order c%0d: got %h want %h", cyc, dn_data[2], next_out); end
        void'(q.pop_front());
        next_out++;
      end else if (mcnt != 0) begin
        checks++; if (dn_data[2] !== q[0]) begin errors++; $display("FAIL wrap_head c%0d: got %h want %h", cyc, dn_data[2], q[0]); end
      end
      if (mpush) begin
        q.push_back(64'(next_in));
        next_in++;
      end
      mcnt = mcnt + int'(mpush) - int'(mpop);
      tick();
    end
    checks++; if (next_out != 8) begin errors++; $display("FAIL wrap_timeout: got %0d outputs want 7", next_out - 1); end
    idle_all();
  endtask

  // Scenario 4: flush with concurrent push and pop, with and without clear.
  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 2; i++) begin up_valid[i] = 1'b1; up_data[i] = 64'h11; end
    tick();
    for (int i = 0; i < 2; i++) up_data[i] = 64'h22;
    tick();
    for (int i = 0; i < 2; i++) begin
      flush[i] = 1'b1; up_valid[i] = 1'b1; up_data[i] = 64'hD; dn_allow[i] = 1'b1;
    end
    #1;
    checks++; if (up_allow[1] !== 1'b1) begin errors++; $display("FAIL flush_allow_ungated: got %b want 1", up_allow[1]); end
    tick();
    idle_all();
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (dn_valid[i] !== 1'b0) begin errors++; $display("FAIL flush_dn_valid[%0d]: got %b want 0", i, dn_valid[i]); end
    end
    checks++; if (cnt0 !== 2'd0) begin errors++; $display("FAIL flush_count0: got %0d want 0", cnt0); end
    checks++; if (cnt1 !== 2'd0) begin errors++; $display("FAIL flush_count1: got %0d want 0", cnt1); end
    checks++; if (dn_data[0] !== 64'h11) begin errors++; $display("FAIL flush_stale_data: got %h want 11", dn_data[0]); end
    checks++; if (dn_data[1] !== 64'h0) begin errors++; $display("FAIL flush_cleared_data: got %h want 0", dn_data[1]); end
    for (int i = 0; i < 2; i++) begin up_valid[i] = 1'b1; up_data[i] = 64'h33; end
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (dn_data[i] !== 64'h33) begin errors++; $display("FAIL postflush_head[%0d]: got %h want 33", i, dn_data[i]); end
    end
    checks++; if (cnt0 !== 2'd1) begin errors++; $display("FAIL postflush_count0: got %0d want 1", cnt0); end
    checks++; if (cnt1 !== 2'd1) begin errors++; $display("FAIL postflush_count1: got %0d want 1", cnt1); end
    idle_all();
  endtask

  // Scenario 5: asynchronous reset between edges with two entries held.
  task automatic test_async_reset();
    apply_reset();
    up_valid[0] = 1'b1; up_data[0] = 64'h44;
    tick();
    up_data[0] = 64'h55;
    tick();
    checks++; if (cnt0 !== 2'd2) begin errors++; $display("FAIL areset_pre_count: got %0d want 2", cnt0); end
    up_valid[0] = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (cnt0 !== 2'd0) begin errors++; $display("FAIL areset_count: got %0d want 0", cnt0); end
    checks++; if (dn_valid[0] !== 1'b0) begin errors++; $display("FAIL areset_dn_valid: got %b want 0", dn_valid[0]); end
    checks++; if (dn_data[0] !== 64'h0) begin errors++; $display("FAIL areset_dn_data: got %h want 0", dn_data[0]); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    up_valid[0] = 1'b1; up_data[0] = 64'h66;
    #1;
    checks++; if (dn_valid[0] !== 1'b0) begin errors++; $display("FAIL areset_no_bypass: got %b want 0", dn_valid[0]); end
    tick();
    up_valid[0] = 1'b0;
    checks++; if (dn_valid[0] !== 1'b1) begin errors++; $display("FAIL areset_first_valid: got %b want 1", dn_valid[0]); end
    checks++; if (dn_data[0] !== 64'h66) begin errors++; $display("FAIL areset_first_data: got %h want 66", dn_data[0]); end
    checks++; if (cnt0 !== 2'd1) begin errors++; $display("FAIL areset_first_count: got %0d want 1", cnt0); end
    idle_all();
  endtask

  // Scenario 6: DEPTH=1 PASS_ALLOW=1 against a legacy one-register stage.
  task automatic test_single_entry();
    logic [9:0]  uv_pat;
    logic [9:0]  da_pat;
    bit          lv;
    bit          lallow;
    logic [63:0] ld;
    apply_reset();
    uv_pat = 10'b11_1111_1011;
    da_pat = 10'b11_1110_1111;
    lv = 1'b0;
    ld = '0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      up_valid[3] = uv_pat[cyc];
      up_data[3]  = 64'h100 + 64'(cyc);
      dn_allow[3] = da_pat[cyc];
      #1;
      lallow = !lv || dn_allow[3];
      checks++; if (up_allow[3] !== lallow) begin errors++; $display("FAIL legacy_allow c%0d: got %b want %b", cyc, up_allow[3], lallow); end
      checks++; if (dn_valid[3] !== lv) begin errors++; $display("FAIL legacy_valid c%0d: got %b want %b", cyc, dn_valid[3], lv); end
      checks++; if (cnt3 !== 1'(lv)) begin errors++; $display("FAIL legacy_count c%0d: got %0d want %0d", cyc, cnt3, lv); end
      checks++; if (dn_data[3] !== ld) begin errors++; $display("FAIL legacy_data c%0d: got %h want %h", cyc, dn_data[3], ld); end
      if (lallow) begin
        if (up_valid[3]) ld = up_data[3];
        lv = up_valid[3];
      end
      tick();
    end
    idle_all();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_fill_and_pass();
    test_wrap();
    test_flush();
    test_async_reset();
    test_single_entry();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_210247_pipe_buf.md
Name: ysyx_210247_pipe_buf

Overview:
Parametrised elastic pipeline stage that replaces the single-entry inter-stage register (IF/ID/EXE/MEM/WB boundaries) with a DEPTH-entry buffer. It uses the same valid/allow handshake on both sides. It provides:
- optional registered allow, which cuts the combinational allow chain between stages;
- synchronous flush;
- an occupancy count.
With DEPTH=1 and PASS_ALLOW=1 it is cycle-equivalent to the existing one-entry stage register.

Parameters:
DW, 64, payload width in bits; set from the stage bus widths in defines.v, e.g. ID_TO_EXE_BUS.
DEPTH, 2, number of entries, 1..8; need not be a power of two.
PASS_ALLOW, 0, 1 = up_allow_out also asserts when full and dn_allow_in=1 (combinational path); 0 = up_allow_out depends on registered state only.
CLEAR_ON_FLUSH, 0, 1 = flush also zeroes all storage entries.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous discard of all buffered entries.
up_valid_out  in  1  upstream stage has a valid payload.
up_data  in  DW  upstream payload.
up_allow_out  out  1  buffer accepts a payload this cycle.
dn_valid_in  out  1  head entry is valid.
dn_data  out  DW  head entry payload.
dn_allow_in  in  1  downstream consumes head this cycle.
count  out  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Reset (rst_n=0, asynchronous assert, synchronous deassert handled externally):
  - count=0, rd_ptr=wr_ptr=0;
  - all storage entries =0, so dn_data=0;
  - dn_valid_in=0;
  - up_allow_out=1 (PASS_ALLOW=0) or (count<DEPTH)|dn_allow_in (PASS_ALLOW=1), i.e. 1 out of reset.
- Push: push = up_valid_out & up_allow_out. Payload is written to mem[wr_ptr]; wr_ptr advances.
- Pop: pop = dn_valid_in & dn_allow_in. rd_ptr advances.
- Pointers increment modulo DEPTH explicitly: DEPTH-1 wraps to 0. Pointer width is max(1,$clog2(DEPTH)).
- dn_valid_in = (count!=0). dn_data = mem[rd_ptr], driven combinationally from storage.
- Latency: a payload pushed in cycle N is visible on dn_valid_in/dn_data in cycle N+1. There is no same-cycle bypass.
- up_allow_out:
  - PASS_ALLOW=0: (count<DEPTH).
  - PASS_ALLOW=1: (count<DEPTH) | dn_allow_in.
- Full, PASS_ALLOW=1, dn_allow_in=1, up_valid_out=1: push and pop occur in the same cycle; count stays DEPTH.
- Empty with dn_allow_in=1: no pop; count is never decremented below 0.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Flush (highest priority, synchronous):
  - next cycle: count=0, rd_ptr=wr_ptr=0, dn_valid_in=0;
  - any push or pop in the flush cycle is discarded;
  - storage is zeroed only if CLEAR_ON_FLUSH=1; otherwise dn_data shows stale mem[0];
  - up_allow_out is not gated by flush.
- Reset mid-operation: immediately returns every output to its reset value, regardless of flush or handshakes.
- dn_data is don't-care when dn_valid_in=0, except that it is 0 after reset.
- Assertions:
  - count<=DEPTH at all times;
  - a push when full and not popping is impossible.

Decomposition:
- Shared package/defines.v: stage bus widths (IF_TO_ID_BUS, ID_TO_EXE_BUS, ...) and a PIPE_BUF_MAX_DEPTH=8 constant.
- One sub-module, ysyx_210247_pipe_buf_mem: DEPTH x DW register array with async reset, write port (we, waddr, wdata), clear input for flush, and combinational read port.
- Pointer, count and handshake logic stay in the top module.

Test Plan:
1. Reset, then DW=64, DEPTH=2, PASS_ALLOW=0; push 0xA then 0xB back-to-back with dn_allow_in=0:
   - count 1 then 2; up_allow_out=0 after second push;
   - dn_data=0xA; dn_valid_in=1 one cycle after first push.
2. Full buffer from scenario 1, up_valid_out=1 with 0xC, dn_allow_in=1:
   - PASS_ALLOW=0: only a pop happens, count=1, dn_data=0xB; 0xC is pushed the next cycle.
   - PASS_ALLOW=1: push and pop in the same cycle, count stays 2, order out is 0xB, 0xC.
3. DEPTH=3, stream 0x1..0x7 with dn_allow_in toggling every cycle:
   - output order is exactly 0x1..0x7;
   - pointers wrap 2->0 with no loss or duplication;
   - count never exceeds 3.
4. count=2, flush=1 with simultaneous up_valid_out=1 (0xD) and dn_allow_in=1:
   - next cycle count=0, dn_valid_in=0, 0xD is not stored;
   - with CLEAR_ON_FLUSH=1, dn_data=0.
5. Mid-stream, count=2, assert rst_n=0 between clock edges:
   - dn_valid_in=0, count=0, dn_data=0 immediately, without waiting for a clock edge;
   - after release, the first push appears on dn_data one cycle later.
6. DEPTH=1, PASS_ALLOW=1, continuous up_valid_out with dn_allow_in=1:
   - one transfer per cycle, latency 1;
   - output trace matches the legacy single-register stage cycle for cycle.
